dyser_output_port: RTL and testbench
====================================

// Module: dyser_output_port
// PURPOSE
//  Credit-flow-controlled output buffer directly downstream of the last DySER flip-flop stage.
//  Accepts {data,valid} words from the stage's ready/credit handshake and stores them in a DEPTH-entry FIFO.
//  Presents them to the host processor through a valid/ack pop interface.
//  Decouples fabric throughput from processor consumption rate.
// PARAMETERS
//  ID     0  port index; informational only, no functional effect
//  DEPTH  4  FIFO entries; power of two, >= 2
//  AW     2  pointer width, log2(DEPTH)
// PORTS
//  clk          in   1                clock
//  rst_n        in   1                reset, asynchronous, active-low
//  ready_in     in   1                upstream stage holds a word (its ready_out)
//  valid_in     in   1                phi-valid bit accompanying the word
//  data_in      in   `DATA_WIDTH+1    word from the upstream stage (its data_out)
//  credit_out   out  1                room available; drives upstream credit_in
//  flush        in   1                synchronous discard of all entries
//  out_ack      in   1                host pops the head entry
//  out_rdy      out  1                head entry present
//  out_data     out  `DATA_WIDTH+1    head data
//  out_valid    out  1                head phi-valid bit
//  count        out  AW+1             occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset: pointers=0; count=0; out_rdy=0; credit_out=1; out_data=0; out_valid=0; storage need not clear.
//  - credit_out = (count != DEPTH) & ~flush. Level signal, combinational from registered count.
//  - push = ready_in & credit_out. Word is written at wr_ptr on the clk edge. Upstream leaves NR on that same edge.
//  - pop = out_ack & out_rdy. Head advances on the clk edge. out_ack while empty is ignored.
//  - out_rdy = (count != 0). out_data/out_valid come combinationally from mem[rd_ptr]; 0 when empty.
//  - Latency: a pushed word is visible on out_rdy the cycle after the push edge. There is no fall-through.
//  - Push and pop in the same cycle: both occur and count is unchanged. Allowed at any count 1..DEPTH-1.
//  - Full (count==DEPTH): credit_out=0, so no push. A pop in that cycle lowers count to DEPTH-1.
//    credit_out rises the next cycle. Same-cycle pop-to-push bypass is not allowed.
//  - Empty: pop is ignored. A push makes count=1.
//  - Pointers wrap modulo DEPTH. count saturates at neither bound, because the handshake guarantees legality.
//  - flush=1: next edge sets pointers=0 and count=0. Any push or pop in that cycle is discarded.
//    credit_out is 0 during the flush cycle, so upstream keeps its word.
//  - Reset mid-operation: all contents are lost immediately (async). credit_out=1 on reset release.
//  - No combinational path ready_in -> credit_out or out_ack -> out_rdy.
// CONFIGURATION
//  - DYSER_OUTPORT_STATS_EN defined: adds outputs stat_xfers[31:0] and stat_stalls[31:0].
//    stat_xfers counts push cycles. stat_stalls counts cycles with ready_in & ~credit_out.
//    Both saturate at 32'hFFFF_FFFF, reset to 0 on rst_n, and are unaffected by flush.
//  - Not defined: the counters and ports are absent. Datapath behaviour is identical.
// TESTING
//  - Reset, idle: count=0, out_rdy=0, credit_out=1, out_data=0.
//  - Push 0x11,0x22,0x33,0x44 back-to-back (DEPTH=4) -> count=4, credit_out=0.
//    A 5th ready_in is held off and is not written.
//  - Full, then out_ack one cycle -> out_data=0x11 consumed, count=3, credit_out=1 next cycle.
//    Stalled 0x55 then accepted; pop order is 0x22,0x33,0x44,0x55.
//  - count=2, push and pop in the same cycle for 10 cycles -> count stays 2; data order preserved across pointer wrap.
//  - count=3, flush with ready_in=1 -> count=0, out_rdy=0. The pending word is pushed the cycle after flush.
//  - STATS_EN: 4 pushes then 3 ready_in cycles while full -> stat_xfers=4, stat_stalls=3.
//    The counters hold their values through flush and clear on rst_n.

Source files
------------

// File: rtl/dyser_output_port.sv
// rtl/dyser_output_port.sv - credit-flow-controlled output FIFO between the last DySER stage and the host
// Optional feature macro: DYSER_OUTPORT_STATS_EN adds saturating stat_xfers/stat_stalls counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dyser_output_port #(
   parameter int ID    = 0,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ready_in,
   input  logic                 valid_in,
   input  logic [`DATA_WIDTH:0] data_in,
   output logic                 credit_out,
   input  logic                 flush,
   input  logic                 out_ack,
   output logic                 out_rdy,
   output logic [`DATA_WIDTH:0] out_data,
   output logic                 out_valid,
   output logic [AW:0]          count
`ifdef DYSER_OUTPORT_STATS_EN
   ,
   output logic [31:0]          stat_xfers,
   output logic [31:0]          stat_stalls
`endif
);

   localparam int          DW       = `DATA_WIDTH + 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push;
   logic          pop;
   entry_t        head;

   // ID is a label only; tie it off so it carries no logic.
   logic unused_id;
   assign unused_id = (ID != 0);

   // Credit and ready depend only on registered occupancy (plus flush), never on ready_in/out_ack.
   assign credit_out = (count_q != FULL_CNT) & ~flush;
   assign out_rdy    = (count_q != '0);
   assign push       = ready_in & credit_out;
   assign pop        = out_ack & out_rdy & ~flush;

   assign head      = out_rdy ? mem_q[rd_ptr_q] : '0;
   assign out_data  = head.data;
   assign out_valid = head.valid;
   assign count     = count_q;

   // Next-state for pointers and occupancy; flush wins over any push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents are don't-care until counted in, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{valid: valid_in, data: data_in};
      end
   end

`ifdef DYSER_OUTPORT_STATS_EN
   logic [31:0] xfers_q;
   logic [31:0] stalls_q;
   logic        stall;

   assign stall = ready_in & ~credit_out;

   // Saturating transfer/stall counters; only reset clears them, flush does not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfers_q  <= '0;
         stalls_q <= '0;
      end else begin
         if (push && (xfers_q != 32'hFFFF_FFFF))   xfers_q  <= xfers_q + 32'd1;
         if (stall && (stalls_q != 32'hFFFF_FFFF)) stalls_q <= stalls_q + 32'd1;
      end
   end

   assign stat_xfers  = xfers_q;
   assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_dyser_output_port.sv
// tb/tb_dyser_output_port.sv - randomized self-checking bench for dyser_output_port against a queue model
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_dyser_output_port;

   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int DW    = `DATA_WIDTH + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ready_in;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic          credit_out;
   logic          flush;
   logic          out_ack;
   logic          out_rdy;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic [AW:0]   count;
`ifdef DYSER_OUTPORT_STATS_EN
   logic [31:0]   stat_xfers;
   logic [31:0]   stat_stalls;
`endif

   dyser_output_port #(.ID(0), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ready_in   (ready_in),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .credit_out (credit_out),
      .flush      (flush),
      .out_ack    (out_ack),
      .out_rdy    (out_rdy),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .count      (count)
`ifdef DYSER_OUTPORT_STATS_EN
      ,
      .stat_xfers (stat_xfers),
      .stat_stalls(stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [DW:0] model_q[$];
   logic [31:0] m_xfers  = '0;
   logic [31:0] m_stalls = '0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Called at a negedge: drives one cycle of inputs, checks outputs, advances the model.
   task automatic cycle(input logic rdy, input logic v, input logic [DW-1:0] d,
                        input logic ack, input logic fl, output logic pushed);
      logic        exp_credit;
      logic        exp_push;
      logic        exp_pop;
      logic [DW:0] hd;
      ready_in = rdy;
      valid_in = v;
      data_in  = d;
      out_ack  = ack;
      flush    = fl;
      #1;
      exp_credit = (model_q.size() != DEPTH) && !fl;
      hd         = (model_q.size() != 0) ? model_q[0] : '0;
      check_eq("count",      64'(count),      64'(model_q.size()));
      check_eq("out_rdy",    64'(out_rdy),    64'(model_q.size() != 0));
      check_eq("out_data",   64'(out_data),   64'(hd[DW-1:0]));
      check_eq("out_valid",  64'(out_valid),  64'(hd[DW]));
      check_eq("credit_out", 64'(credit_out), 64'(exp_credit));
      exp_push = rdy && exp_credit;
      exp_pop  = ack && (model_q.size() != 0) && !fl;
      @(posedge clk);
      if (fl) begin
         model_q.delete();
      end else begin
         if (exp_pop)  void'(model_q.pop_front());
         if (exp_push) model_q.push_back({v, d});
      end
      if (exp_push && m_xfers != 32'hFFFF_FFFF)       m_xfers++;
      if (rdy && !exp_credit && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      pushed = exp_push;
      @(negedge clk);
`ifdef DYSER_OUTPORT_STATS_EN
      check_eq("stat_xfers",  64'(stat_xfers),  64'(m_xfers));
      check_eq("stat_stalls", 64'(stat_stalls), 64'(m_stalls));
`endif
   endtask

   // Asserts reset away from any clock edge and checks its immediate effect.
   task automatic do_reset();
      ready_in = 1'b0;
      out_ack  = 1'b0;
      flush    = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_count",      64'(count),      64'd0);
      check_eq("rst_out_rdy",    64'(out_rdy),    64'd0);
      check_eq("rst_credit_out", 64'(credit_out), 64'd1);
      check_eq("rst_out_data",   64'(out_data),   64'd0);
      check_eq("rst_out_valid",  64'(out_valid),  64'd0);
`ifdef DYSER_OUTPORT_STATS_EN
      check_eq("rst_stat_xfers",  64'(stat_xfers),  64'd0);
      check_eq("rst_stat_stalls", 64'(stat_stalls), 64'd0);
`endif
      model_q.delete();
      m_xfers  = '0;
      m_stalls = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic          p;
      logic          have;
      logic          wv;
      logic [DW-1:0] w;
      logic [DW-1:0] exp_order[4];
      int            ack_pct;

      rst_n    = 1'b0;
      ready_in = 1'b0;
      valid_in = 1'b0;
      data_in  = '0;
      flush    = 1'b0;
      out_ack  = 1'b0;
      @(negedge clk);
      do_reset();
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, p);

      // Fill to full with 0x11..0x44, fifth word held off.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'((i + 1) * 17), 1'b0, 1'b0, p);
      check_eq("full_count",  64'(count),      64'd4);
      check_eq("full_credit", 64'(credit_out), 64'd0);
      cycle(1'b1, 1'b0, DW'(8'h55), 1'b0, 1'b0, p);
      check_eq("fifth_not_written", 64'(count), 64'd4);
      check_eq("full_head", 64'(out_data), 64'h11);
      cycle(1'b1, 1'b0, DW'(8'h55), 1'b1, 1'b0, p);
      check_eq("pop_from_full_count", 64'(count),      64'd3);
      check_eq("credit_reopen",       64'(credit_out), 64'd1);
      cycle(1'b1, 1'b0, DW'(8'h55), 1'b0, 1'b0, p);
      exp_order[0] = DW'(8'h22);
      exp_order[1] = DW'(8'h33);
      exp_order[2] = DW'(8'h44);
      exp_order[3] = DW'(8'h55);
      for (int i = 0; i < 4; i++) begin
         check_eq("pop_order", 64'(out_data), 64'(exp_order[i]));
         cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, p);
      end
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, p);
      check_eq("ack_when_empty", 64'(count), 64'd0);

      // Simultaneous push and pop at count=2 across pointer wrap.
      cycle(1'b1, 1'b1, DW'(16'h0A0), 1'b0, 1'b0, p);
      cycle(1'b1, 1'b0, DW'(16'h0A1), 1'b0, 1'b0, p);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, k[0], DW'(16'h100 + k), 1'b1, 1'b0, p);
         check_eq("pushpop_count", 64'(count), 64'd2);
      end
      check_eq("pushpop_head", 64'(out_data), 64'h108);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, p);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, p);

      // Flush at count=3 with a pending upstream word.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'(8'h60 + i), 1'b0, 1'b0, p);
      cycle(1'b1, 1'b1, DW'(8'h77), 1'b1, 1'b1, p);
      check_eq("flush_count",   64'(count),   64'd0);
      check_eq("flush_out_rdy", 64'(out_rdy), 64'd0);
      cycle(1'b1, 1'b1, DW'(8'h77), 1'b0, 1'b0, p);
      check_eq("post_flush_count", 64'(count),    64'd1);
      check_eq("post_flush_data",  64'(out_data), 64'h77);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, p);

`ifdef DYSER_OUTPORT_STATS_EN
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'(i), 1'b0, 1'b0, p);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'(9), 1'b0, 1'b0, p);
      check_eq("stats_xfers_4",  64'(stat_xfers),  64'd4);
      check_eq("stats_stalls_3", 64'(stat_stalls), 64'd3);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, p);
      check_eq("stats_xfers_hold",  64'(stat_xfers),  64'd4);
      check_eq("stats_stalls_hold", 64'(stat_stalls), 64'd3);
`endif

      // Randomized traffic with a well-behaved upstream and a bursty host.
      do_reset();
      have = 1'b0;
      wv   = 1'b0;
      w    = '0;
      for (int c = 0; c < 800; c++) begin
         if (!have && $urandom_range(0, 3) != 0) begin
            have = 1'b1;
            w    = DW'({$urandom(), $urandom()});
            wv   = 1'($urandom_range(0, 1));
         end
         ack_pct = ((c / 100) % 2 == 0) ? 25 : 80;
         cycle(have, wv, w, ($urandom_range(0, 99) < ack_pct), ($urandom_range(0, 49) == 0), p);
         if (p) have = 1'b0;
         if (c == 400) begin
            do_reset();
            have = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
